// File: rtl/axil_master_bridge.sv
// Single-outstanding AXI4-Lite initiator: one valid/ready request becomes one AXI-Lite
// read or write, and the response comes back with its code and its latency in cycles.
module axil_master_bridge #(
   parameter int unsigned ADDR_WIDTH = 32,
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned STRB_WIDTH = DATA_WIDTH/8,
   parameter logic [2:0]  PROT       = 3'b000
) (
   input  logic                  aclk,
   input  logic                  aresetn,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic                  req_write,
   input  logic [ADDR_WIDTH-1:0] req_addr,
   input  logic [DATA_WIDTH-1:0] req_wdata,
   input  logic [STRB_WIDTH-1:0] req_wstrb,
   output logic                  rsp_valid,
   input  logic                  rsp_ready,
   output logic                  rsp_write,
   output logic [DATA_WIDTH-1:0] rsp_rdata,
   output logic [1:0]            rsp_resp,
   output logic [15:0]           rsp_cycles,
   output logic [ADDR_WIDTH-1:0] m_axil_awaddr,
   output logic [2:0]            m_axil_awprot,
   output logic                  m_axil_awvalid,
   input  logic                  m_axil_awready,
   output logic [DATA_WIDTH-1:0] m_axil_wdata,
   output logic [STRB_WIDTH-1:0] m_axil_wstrb,
   output logic                  m_axil_wvalid,
   input  logic                  m_axil_wready,
   input  logic [1:0]            m_axil_bresp,
   input  logic                  m_axil_bvalid,
   output logic                  m_axil_bready,
   output logic [ADDR_WIDTH-1:0] m_axil_araddr,
   output logic [2:0]            m_axil_arprot,
   output logic                  m_axil_arvalid,
   input  logic                  m_axil_arready,
   input  logic [DATA_WIDTH-1:0] m_axil_rdata,
   input  logic [1:0]            m_axil_rresp,
   input  logic                  m_axil_rvalid,
   output logic                  m_axil_rready
);

   typedef enum logic [2:0] {IDLE, WR_REQ, WR_RESP, RD_REQ, RD_DATA, RESP} state_t;

   localparam logic [ADDR_WIDTH-1:0] ADDR_LOW_MASK = ADDR_WIDTH'(3);

   state_t                state_q, state_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
   logic [STRB_WIDTH-1:0] wstrb_q, wstrb_d;
   logic                  req_ready_q, req_ready_d;
   logic                  awvalid_q, awvalid_d;
   logic                  wvalid_q, wvalid_d;
   logic                  bready_q, bready_d;
   logic                  arvalid_q, arvalid_d;
   logic                  rready_q, rready_d;
   logic                  rsp_valid_q, rsp_valid_d;
   logic                  rsp_write_q, rsp_write_d;
   logic [DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
   logic [1:0]            rsp_resp_q, rsp_resp_d;
   logic [15:0]           cycles_q, cycles_d, cycles_inc;

   always_ff @(posedge aclk) begin
      if (!aresetn) begin
         state_q     <= IDLE;
         addr_q      <= '0;
         wdata_q     <= '0;
         wstrb_q     <= '0;
         req_ready_q <= 1'b1;
         awvalid_q   <= 1'b0;
         wvalid_q    <= 1'b0;
         bready_q    <= 1'b0;
         arvalid_q   <= 1'b0;
         rready_q    <= 1'b0;
         rsp_valid_q <= 1'b0;
         rsp_write_q <= 1'b0;
         rsp_rdata_q <= '0;
         rsp_resp_q  <= '0;
         cycles_q    <= '0;
      end else begin
         state_q     <= state_d;
         addr_q      <= addr_d;
         wdata_q     <= wdata_d;
         wstrb_q     <= wstrb_d;
         req_ready_q <= req_ready_d;
         awvalid_q   <= awvalid_d;
         wvalid_q    <= wvalid_d;
         bready_q    <= bready_d;
         arvalid_q   <= arvalid_d;
         rready_q    <= rready_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_write_q <= rsp_write_d;
         rsp_rdata_q <= rsp_rdata_d;
         rsp_resp_q  <= rsp_resp_d;
         cycles_q    <= cycles_d;
      end
   end

   // The latency counter doubles as the rsp_cycles output; it only moves while a transaction is open.
   assign cycles_inc = (cycles_q == 16'hFFFF) ? cycles_q : cycles_q + 16'd1;

   always_comb begin
      state_d     = state_q;
      addr_d      = addr_q;
      wdata_d     = wdata_q;
      wstrb_d     = wstrb_q;
      req_ready_d = req_ready_q;
      awvalid_d   = awvalid_q;
      wvalid_d    = wvalid_q;
      bready_d    = bready_q;
      arvalid_d   = arvalid_q;
      rready_d    = rready_q;
      rsp_valid_d = rsp_valid_q;
      rsp_write_d = rsp_write_q;
      rsp_rdata_d = rsp_rdata_q;
      rsp_resp_d  = rsp_resp_q;
      cycles_d    = cycles_q;
      case (state_q)
         IDLE: begin
            if (req_valid && req_ready_q) begin
               addr_d      = req_addr & ~ADDR_LOW_MASK;
               wdata_d     = req_wdata;
               wstrb_d     = req_wstrb;
               req_ready_d = 1'b0;
               cycles_d    = '0;
               if (req_write) begin
                  awvalid_d = 1'b1;
                  wvalid_d  = 1'b1;
                  state_d   = WR_REQ;
               end else begin
                  arvalid_d = 1'b1;
                  state_d   = RD_REQ;
               end
            end
         end
         WR_REQ: begin
            cycles_d = cycles_inc;
            if (awvalid_q && m_axil_awready) awvalid_d = 1'b0;
            if (wvalid_q && m_axil_wready)   wvalid_d  = 1'b0;
            if (!awvalid_d && !wvalid_d) begin
               bready_d = 1'b1;
               state_d  = WR_RESP;
            end
         end
         WR_RESP: begin
            cycles_d = cycles_inc;
            if (m_axil_bvalid) begin
               bready_d    = 1'b0;
               rsp_resp_d  = m_axil_bresp;
               rsp_rdata_d = '0;
               rsp_write_d = 1'b1;
               rsp_valid_d = 1'b1;
               state_d     = RESP;
            end
         end
         RD_REQ: begin
            cycles_d = cycles_inc;
            if (m_axil_arready) begin
               arvalid_d = 1'b0;
               rready_d  = 1'b1;
               state_d   = RD_DATA;
            end
         end
         RD_DATA: begin
            cycles_d = cycles_inc;
            if (m_axil_rvalid) begin
               rready_d    = 1'b0;
               rsp_resp_d  = m_axil_rresp;
               rsp_rdata_d = m_axil_rdata;
               rsp_write_d = 1'b0;
               rsp_valid_d = 1'b1;
               state_d     = RESP;
            end
         end
         RESP: begin
            if (rsp_ready) begin
               rsp_valid_d = 1'b0;
               req_ready_d = 1'b1;
               state_d     = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign req_ready      = req_ready_q;
   assign rsp_valid      = rsp_valid_q;
   assign rsp_write      = rsp_write_q;
   assign rsp_rdata      = rsp_rdata_q;
   assign rsp_resp       = rsp_resp_q;
   assign rsp_cycles     = cycles_q;
   assign m_axil_awaddr  = addr_q;
   assign m_axil_awprot  = PROT;
   assign m_axil_awvalid = awvalid_q;
   assign m_axil_wdata   = wdata_q;
   assign m_axil_wstrb   = wstrb_q;
   assign m_axil_wvalid  = wvalid_q;
   assign m_axil_bready  = bready_q;
   assign m_axil_araddr  = addr_q;
   assign m_axil_arprot  = PROT;
   assign m_axil_arvalid = arvalid_q;
   assign m_axil_rready  = rready_q;

endmodule

// File: doc/axil_master_bridge.md
Name: axil_master_bridge

Overview:
- Single-outstanding AXI4-Lite initiator.
- Turns a simple valid/ready request/response port into AXI4-Lite read or write transactions.
- Used by internal engines (loaders, test sequencers) to reach memory-mapped slaves such as the SDRAM AXI-Lite slave.
- Reports the response code and the transaction latency in cycles.

Parameters:
ADDR_WIDTH, 32, AXI and request address width
DATA_WIDTH, 32, data width; must be 32
STRB_WIDTH, DATA_WIDTH/8, write strobe width
PROT, 3'b000, constant driven on awprot/arprot

Ports:
aclk  in  1  clock for all logic
aresetn  in  1  reset: one clock; reset is synchronous and active-low
req_valid  in  1  request offered
req_ready  out  1  request accepted when high with req_valid
req_write  in  1  1=write, 0=read
req_addr  in  ADDR_WIDTH  byte address
req_wdata  in  DATA_WIDTH  write data
req_wstrb  in  STRB_WIDTH  write byte strobes
rsp_valid  out  1  response available
rsp_ready  in  1  response consumed
rsp_write  out  1  response belongs to a write
rsp_rdata  out  DATA_WIDTH  read data (0 for writes)
rsp_resp  out  2  BRESP/RRESP copy
rsp_cycles  out  16  cycles from acceptance to B/R handshake, saturating
m_axil_awaddr/awprot/awvalid out, awready in  AW channel
m_axil_wdata/wstrb/wvalid out, wready in  W channel
m_axil_bresp/bvalid in, bready out  B channel
m_axil_araddr/arprot/arvalid out, arready in  AR channel
m_axil_rdata/rresp/rvalid in, rready out  R channel

Behaviour:
- States: IDLE, WR_REQ, WR_RESP, RD_REQ, RD_DATA, RESP.
- All outputs are registered.
- Reset values: every valid/ready output 0 except req_ready=1; data, address, resp and rsp_cycles outputs 0. State = IDLE.
- IDLE:
  - req_ready=1.
  - On req_valid&&req_ready: capture all request fields; req_ready drops next cycle.
  - Go to WR_REQ if req_write, else RD_REQ.
- Address: awaddr/araddr = captured address with bits [1:0] forced to 0.
- WR_REQ:
  - awvalid and wvalid rise the cycle after acceptance.
  - Each channel is tracked independently. A valid drops the cycle after its own handshake and is never reasserted for this transaction.
  - Payload is stable while its valid is high.
  - When both channels are done (same or different cycles), go to WR_RESP.
- WR_RESP:
  - bready=1.
  - On bvalid: latch bresp, rsp_rdata=0, rsp_write=1; go to RESP.
- RD_REQ:
  - arvalid=1 until arready, then go to RD_DATA.
- RD_DATA:
  - rready=1.
  - On rvalid: latch rdata and rresp, rsp_write=0; go to RESP.
- RESP:
  - rsp_valid=1; rsp fields stable.
  - On rsp_ready: rsp_valid=0, go to IDLE, req_ready=1 the next cycle.
- Latency, zero-wait slave: accept at cycle N; aw/w handshake at N+1; B handshake at N+2; rsp_valid at N+3 with rsp_cycles=2. Reads have the same timing.
- rsp_cycles:
  - Cleared at acceptance; +1 per cycle until the B/R handshake.
  - Saturates at 16'hFFFF.
- No timeout: the block waits indefinitely for the slave.
- wstrb=0 is issued unmodified.
- SLVERR/DECERR are only reported; no retry.
- Reset mid-transaction: next cycle all AXI valids/readies drop, rsp_valid=0, state IDLE, req_ready=1. An in-flight response is discarded.
- bvalid/rvalid outside the WR_RESP/RD_DATA states are ignored (bready/rready low).

Test Plan:
- Zero-wait write: addr 0x0000_0104, wdata 0xDEADBEEF, wstrb 4'hF -> AW/W handshake the same cycle, awaddr 0x104; rsp_valid 3 cycles after acceptance; rsp_resp 0, rsp_write 1, rsp_cycles 2.
- Skewed write: awready delayed 5 cycles, wready immediate -> wvalid high 1 cycle, awvalid high 6 cycles; bready only after both done; rsp_cycles 7.
- Read with wait: addr 0x0000_0203, arready after 2 cycles, rvalid after 4 more with rdata 0x12345678, rresp 2'b10 -> araddr 0x200; rsp_rdata 0x12345678, rsp_resp 2'b10, rsp_write 0.
- Backpressure: rsp_ready held low 10 cycles, new req_valid asserted -> req_ready stays 0 and rsp fields stay stable; accepted the cycle after rsp_ready.
- Reset mid-op: aresetn low while awvalid high -> next cycle awvalid=wvalid=rsp_valid=0, req_ready=1. A following read completes normally.
- Saturation: rvalid withheld 70000 cycles -> rsp_cycles = 16'hFFFF.
